// File: rtl/window_pkg.sv
// rtl/window_pkg.sv - shared types and constants for the measurement-window generator
//
// Purpose: state encoding and default timing constants used by window_gen.
// Ports:   none (package).

package window_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 0.1 ms window at the nominal 100 MHz system clock
  localparam int DEFAULT_WIN_LEN = 10_000;
  localparam int CLK_HZ          = 100_000_000;

endpackage

// File: rtl/win_sat_ctr.sv
// rtl/win_sat_ctr.sv - saturating event counter
//
// Purpose: counts single-cycle increment requests and holds at all-ones.
// Ports:
//   clk    in      clock
//   rst_n  in      asynchronous active-low reset
//   inc    in      count one event this cycle
//   count  out [W] current count, saturating

module win_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/window_gen.sv
// rtl/window_gen.sv - programmable measurement-window generator
//
// Purpose: opens gated windows of programmable length for the ring-oscillator
//          edge counters, one-shot or continuous with an optional gap.
// Ports:
//   clk           in            system clock
//   rst_n         in            asynchronous active-low reset
//   en            in            master enable; low aborts immediately
//   oneshot       in            1 = one window per start pulse, 0 = continuous
//   start         in            one-shot trigger
//   win_len       in  [CNT_W]   window length, sampled at window entry
//   gap_len       in  [CNT_W]   continuous-mode gap, sampled at window entry
//   window_open   out           high while a window is open
//   window_start  out           first open cycle
//   window_done   out           last open cycle
//   window_abort  out           window was cut short by en=0
//   busy          out           not idle
//   win_count     out [WCNT_W]  completed windows, saturating
//   cfg_err       out           sticky: zero window length was sampled

module window_gen
  import window_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              oneshot,
  input  logic              start,
  input  logic [CNT_W-1:0]  win_len,
  input  logic [CNT_W-1:0]  gap_len,
  output logic              window_open,
  output logic              window_start,
  output logic              window_done,
  output logic              window_abort,
  output logic              busy,
  output logic [WCNT_W-1:0] win_count,
  output logic              cfg_err
);

  state_t           state;
  logic [CNT_W-1:0] ct;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] gap_q;
  logic             abort_q;
  logic             cfg_err_q;

  // len_q is never 0 once latched, so len_q-1 cannot wrap; gap_last is only
  // consulted in GAP, which is entered only with gap_q > 0.
  logic run_last;
  logic gap_last;
  logic entry;

  assign run_last = (ct == len_q - CNT_W'(1));
  assign gap_last = (ct == gap_q - CNT_W'(1));
  assign entry    = en && (!oneshot || start);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ct        <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (entry) begin
            len_q <= (win_len == '0) ? CNT_W'(1) : win_len;
            gap_q <= gap_len;
            if (win_len == '0) cfg_err_q <= 1'b1;
            ct    <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (!en) begin
            // en dominates even on the last cycle: the window is not counted
            state   <= IDLE;
            ct      <= '0;
            abort_q <= 1'b1;
          end else if (run_last) begin
            ct <= '0;
            if (oneshot) begin
              state <= IDLE;
            end else if (gap_q == '0) begin
              len_q <= (win_len == '0) ? CNT_W'(1) : win_len;
              gap_q <= gap_len;
              if (win_len == '0) cfg_err_q <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            ct <= ct + CNT_W'(1);
          end
        end
        GAP: begin
          if (!en || oneshot) begin
            state <= IDLE;
            ct    <= '0;
          end else if (gap_last) begin
            len_q <= (win_len == '0) ? CNT_W'(1) : win_len;
            gap_q <= gap_len;
            if (win_len == '0) cfg_err_q <= 1'b1;
            ct    <= '0;
            state <= RUN;
          end else begin
            ct <= ct + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          ct    <= '0;
        end
      endcase
    end
  end

  win_sat_ctr #(
    .W(WCNT_W)
  ) u_wcount (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (en && (state == RUN) && run_last),
    .count (win_count)
  );

  assign window_open  = (state == RUN);
  assign window_start = (state == RUN) && (ct == '0);
  assign window_done  = (state == RUN) && run_last;
  assign window_abort = abort_q;
  assign busy         = (state != IDLE);
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - self-checking bench for window_gen

module tb_window_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        oneshot;
  logic        start;
  logic [31:0] win_len;
  logic [31:0] gap_len;
  logic        window_open, window_start, window_done, window_abort, busy, cfg_err;
  logic [15:0] win_count;
  logic        s_open, s_start, s_done, s_abort, s_busy, s_cfg;
  logic [1:0]  sat_wcount;

  int vectors = 0;
  int miscompares = 0;
  int exp_wc = 0;
  logic exp_cfg = 1'b0;

  always #5 clk = ~clk;

  window_gen #(.CNT_W(32), .WCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .oneshot(oneshot), .start(start),
    .win_len(win_len), .gap_len(gap_len),
    .window_open(window_open), .window_start(window_start), .window_done(window_done),
    .window_abort(window_abort), .busy(busy), .win_count(win_count), .cfg_err(cfg_err)
  );

  window_gen #(.CNT_W(32), .WCNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .oneshot(oneshot), .start(start),
    .win_len(win_len), .gap_len(gap_len),
    .window_open(s_open), .window_start(s_start), .window_done(s_done),
    .window_abort(s_abort), .busy(s_busy), .win_count(sat_wcount), .cfg_err(s_cfg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string nm, input int c, input logic eo, input logic es,
                           input logic ed, input logic eb);
    chk($sformatf("%s open@%0d", nm, c),  window_open,  eo);
    chk($sformatf("%s start@%0d", nm, c), window_start, es);
    chk($sformatf("%s done@%0d", nm, c),  window_done,  ed);
    chk($sformatf("%s busy@%0d", nm, c),  busy,         eb);
    chk($sformatf("%s abort@%0d", nm, c), window_abort, 1'b0);
  endtask

  // Drops en after the last checked cycle; an abort is due iff that cycle was open.
  task automatic finish_run(input string nm, input logic last_open);
    start = 1'b0;
    en    = 1'b0;
    @(posedge clk); #1;
    chk({nm, " abort"},    window_abort, last_open);
    chk({nm, " idle"},     busy,         1'b0);
    chk({nm, " closed"},   window_open,  1'b0);
    chk({nm, " count"},    win_count,    exp_wc[15:0]);
    chk({nm, " cfg_err"},  cfg_err,      exp_cfg);
    @(posedge clk); #1;
    chk({nm, " abort1"},   window_abort, 1'b0);
  endtask

  // Continuous mode: period L+G from cycle 1, first L cycles of each period open.
  task automatic run_cont(input string nm, input int wl, input int gl, input int n);
    int L, P, k;
    logic eo, es, ed, last_open;
    L = (wl == 0) ? 1 : wl;
    P = L + gl;
    last_open = 1'b0;
    win_len = wl; gap_len = gl; oneshot = 1'b0; start = 1'b0; en = 1'b1;
    if (wl == 0) exp_cfg = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      k  = (c - 1) % P;
      eo = (k < L);
      es = eo && (k == 0);
      ed = eo && (k == L - 1);
      chk_cycle(nm, c, eo, es, ed, 1'b1);
      if (ed && c < n) exp_wc++;
      last_open = eo;
    end
    finish_run(nm, last_open);
  endtask

  // One-shot mode: a start accepted at cycle s (when not inside a window)
  // opens cycles s+1 .. s+L with L taken from win_len at that cycle.
  task automatic run_oneshot(input string nm, input bit directed, input int n);
    int s_last, l_last;
    logic eo, es, ed, last_open;
    s_last = -100; l_last = 0; last_open = 1'b0;
    oneshot = 1'b1; start = 1'b0; win_len = 5; gap_len = 0; en = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      eo = (c > s_last) && (c <= s_last + l_last);
      es = eo && (c == s_last + 1);
      ed = eo && (c == s_last + l_last);
      chk_cycle(nm, c, eo, es, ed, eo);
      if (ed && c < n) exp_wc++;
      last_open = eo;
      if (directed) begin
        start = (c == 10) || (c == 13) || (c == 20);
        if (c == 12) win_len = 2;
        if (c == 16) win_len = 5;
      end else begin
        start   = (c < n) && ($urandom_range(0, 3) == 0);
        win_len = $urandom_range(1, 4);
      end
      if (start && c > s_last + l_last) begin
        s_last = c;
        l_last = win_len;
      end
    end
    finish_run(nm, last_open);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; oneshot = 1'b0; start = 1'b0; win_len = 0; gap_len = 0;
    #2;
    chk("rst open",   window_open,  1'b0);
    chk("rst start",  window_start, 1'b0);
    chk("rst done",   window_done,  1'b0);
    chk("rst abort",  window_abort, 1'b0);
    chk("rst busy",   busy,         1'b0);
    chk("rst count",  win_count,    16'd0);
    chk("rst cfg",    cfg_err,      1'b0);
    chk("rst satcnt", sat_wcount,   2'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    run_cont("b2b", 4, 0, 13);
    run_cont("gap", 3, 2, 9);
    run_oneshot("os_dir", 1'b1, 30);

    // oneshot raised during a gap ends the sequence without a new window
    win_len = 2; gap_len = 3; oneshot = 1'b0; en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk_cycle("gos", c, c <= 2, c == 1, c == 2, 1'b1);
    end
    exp_wc++;
    oneshot = 1'b1;
    for (int c = 4; c <= 8; c++) begin
      @(posedge clk); #1;
      chk_cycle("gos", c, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    finish_run("gos", 1'b0);

    // en low with start high stays idle
    oneshot = 1'b1; start = 1'b1; en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("en_dom busy", busy, 1'b0);
    end
    start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_cont($sformatf("rc%0d", i), $urandom_range(1, 6), $urandom_range(0, 3),
               $urandom_range(5, 25));
    end
    run_oneshot("os_rnd", 1'b0, 60);
    run_cont("len0", 0, 0, 4);
    run_cont("len0g", 0, 2, 8);

    // asynchronous reset between clock edges, mid-window
    win_len = 10; gap_len = 0; oneshot = 1'b0; en = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst open",  window_open,  1'b0);
    chk("arst start", window_start, 1'b0);
    chk("arst done",  window_done,  1'b0);
    chk("arst abort", window_abort, 1'b0);
    chk("arst busy",  busy,         1'b0);
    chk("arst count", win_count,    16'd0);
    chk("arst cfg",   cfg_err,      1'b0);
    en = 1'b0;
    #2 rst_n = 1'b1;
    exp_wc = 0; exp_cfg = 1'b0;
    @(posedge clk); #1;

    run_cont("sat", 1, 0, 6);
    chk("sat satcnt", sat_wcount, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
